pixel_arbiter: RTL



---
 rtl/pixel_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pixel_arbiter.sv
// Round-robin owner of the single VGA write port.
// Registers the granted source's pixel stream, drops off-screen pixels.
module pixel_arbiter #(
  parameter int NUM_SRC  = 4,
  parameter int MAX_HOLD = 64,
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [NUM_SRC-1:0]     src_we,
  input  logic [8*NUM_SRC-1:0]   src_x,
  input  logic [7*NUM_SRC-1:0]   src_y,
  input  logic [3*NUM_SRC-1:0]   src_color,
  output logic [NUM_SRC-1:0]     busy,
  output logic                   plot,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic [2:0]             grant_id,
  output logic                   overrun
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [8:0] X_LIM = 9'(SCR_W);
  localparam logic [7:0] Y_LIM = 8'(SCR_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t        state, state_n;
  logic [2:0]    g, g_n;
  logic [2:0]    rr_ptr, rr_n;
  logic [2:0]    gid_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          ovr_n, plot_n;
  logic [7:0]    x_n;
  logic [6:0]    y_n;
  logic [2:0]    c_n;

  logic          cur_req, cur_we;
  logic [7:0]    cur_x;
  logic [6:0]    cur_y;
  logic [2:0]    cur_c;
  logic          any_req;
  logic [2:0]    win;
  logic [2:0]    g_inc;

  // Select the current owner's request and pixel lanes.
  always_comb begin
    cur_req = 1'b0;
    cur_we  = 1'b0;
    cur_x   = '0;
    cur_y   = '0;
    cur_c   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (g == 3'(i)) begin
        cur_req = req[i];
        cur_we  = src_we[i];
        cur_x   = src_x[8*i +: 8];
        cur_y   = src_y[7*i +: 7];
        cur_c   = src_color[3*i +: 3];
      end
    end
  end

  // Winner: requester with the smallest rotated distance from rr_ptr.
  always_comb begin
    int best;
    int d;
    any_req = 1'b0;
    win     = rr_ptr;
    best    = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      d = (i - int'(rr_ptr) + NUM_SRC) % NUM_SRC;
      if (req[i] && d < best) begin
        best    = d;
        win     = 3'(i);
        any_req = 1'b1;
      end
    end
  end

  assign g_inc = (g == 3'(NUM_SRC - 1)) ? 3'd0 : g + 3'd1;

  // Next-state and next-output logic for the grant FSM.
  always_comb begin
    state_n = state;
    g_n     = g;
    gid_n   = grant_id;
    rr_n    = rr_ptr;
    hold_n  = hold_cnt;
    ovr_n   = overrun;
    plot_n  = 1'b0;
    x_n     = x;
    y_n     = y;
    c_n     = colour;
    unique case (state)
      S_IDLE: begin
        if (any_req) begin
          g_n     = win;
          gid_n   = win;
          hold_n  = '0;
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        plot_n = cur_we
               && ({1'b0, cur_x} < X_LIM)
               && ({1'b0, cur_y} < Y_LIM);
        x_n = cur_x;
        y_n = cur_y;
        c_n = cur_c;
        if (hold_cnt != '1)
          hold_n = hold_cnt + HW'(1);
        if (!cur_req) begin
          state_n = S_GAP;
          rr_n    = g_inc;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n = S_GAP;
          ovr_n   = 1'b1;
          rr_n    = g_inc;
        end
      end
      S_GAP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      g        <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      hold_cnt <= '0;
      overrun  <= 1'b0;
      plot     <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
    end else begin
      state    <= state_n;
      g        <= g_n;
      rr_ptr   <= rr_n;
      grant_id <= gid_n;
      hold_cnt <= hold_n;
      overrun  <= ovr_n;
      plot     <= plot_n;
      x        <= x_n;
      y        <= y_n;
      colour   <= c_n;
    end
  end

  // busy is one-cold on the owner, decoded from registers only.
  always_comb begin
    busy = '1;
    if (state == S_GRANT) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (g == 3'(i)) busy[i] = 1'b0;
    end
  end

endmodule
